// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg : shared FSM encodings and counter sizing for sr_deserializer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 4;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_capture_reg.sv
// ---------------------------------------------------------------------------
// sr_capture_reg : shift-in capture register; data_next_o is the value the
// register takes on the next enabled edge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_capture_reg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] data_next_o
);

    logic [WIDTH-1:0] data_q;

    // LSB-first shifts toward bit 0 so the first bit ends in bit 0
    if (LSB_FIRST) begin : g_lsb_first
        assign data_next_o = {bit_i, data_q[WIDTH-1:1]};
    end else begin : g_msb_first
        assign data_next_o = {data_q[WIDTH-2:0], bit_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (shift_i) begin
            data_q <= data_next_o;
        end
    end

    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/sr_deserializer.sv
// ---------------------------------------------------------------------------
// sr_deserializer : start-bit framed serial-to-parallel converter with a
// one-entry valid/ready holding buffer and sticky overrun flag.
// Optional macro SR_DESER_PARITY_EN adds an even-parity bit per frame.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_deserializer
    import sr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             p_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] p_out_q;
    logic             p_valid_q;
    logic             overrun_q;
    logic [WIDTH-1:0] cap_data;
    logic [WIDTH-1:0] cap_next;
    logic             commit_d;
    logic             drop_d;
    logic [WIDTH-1:0] word_d;

    sr_capture_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_capture (
        .clk         (clk),
        .reset       (reset),
        .shift_i     (state_q == ST_DATA),
        .bit_i       (s_in),
        .data_o      (cap_data),
        .data_next_o (cap_next)
    );

`ifdef SR_DESER_PARITY_EN
    logic perr_d;
    logic perr_q;
`endif

    // Without parity the word commits on the edge sampling the last data bit,
    // so it is taken from the capture register's next value.
    always_comb begin
        commit_d = 1'b0;
        word_d   = cap_next;
`ifdef SR_DESER_PARITY_EN
        perr_d   = 1'b0;
`endif
        case (state_q)
            ST_DATA: begin
`ifndef SR_DESER_PARITY_EN
                commit_d = (cnt_q == CNT_LAST);
`endif
            end
            ST_PAR: begin
                commit_d = 1'b1;
                word_d   = cap_data;
`ifdef SR_DESER_PARITY_EN
                perr_d   = (^cap_data) ^ s_in;
`endif
            end
            default: ;
        endcase
    end

    assign drop_d = commit_d & p_valid_q & ~p_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SR_DESER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_in) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
`ifdef SR_DESER_PARITY_EN
                        state_q <= ST_PAR;
`else
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PAR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (commit_d && !drop_d) begin
                p_out_q   <= word_d;
                p_valid_q <= 1'b1;
`ifdef SR_DESER_PARITY_EN
                perr_q    <= perr_d;
`endif
            end else if (p_valid_q && p_ready) begin
                p_valid_q <= 1'b0;
            end

            // A drop on the same edge as a clear keeps the flag set
            overrun_q <= drop_d | (overrun_q & ~clr_overrun);
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;
`ifdef SR_DESER_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sr_deserializer : directed self-checking bench for sr_deserializer
// (WIDTH=4, LSB_FIRST=1). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sr_deserializer;

`ifdef SR_DESER_PARITY_EN
    localparam int FL = 6;
`else
    localparam int FL = 5;
`endif
    localparam logic [5:0] VM_NEW  = 6'(1) << (FL - 1);
    localparam logic [5:0] VM_HELD = (6'(1) << FL) - 6'd1;
    localparam logic [5:0] BM_EXP  = (6'(1) << (FL - 1)) - 6'd1;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_in;
    logic       p_ready;
    logic       clr_overrun;
    logic [3:0] p_out;
    logic       p_valid;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0] vm;
    logic [5:0] bm;

    sr_deserializer #(
        .WIDTH     (4),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_in        (s_in),
        .p_ready     (p_ready),
        .clr_overrun (clr_overrun),
        .p_out       (p_out),
        .p_valid     (p_valid),
        .busy        (busy),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in = b;
        tick();
    endtask

    // bits[0] is the start bit, then data LSB first, then parity
    function automatic logic [5:0] mkf(input logic [3:0] d, input logic par);
        return {par, d, 1'b1};
    endfunction

    task automatic send_frame(input logic [5:0] bits, output logic [5:0] vmask, output logic [5:0] bmask);
        vmask = '0;
        bmask = '0;
        for (int i = 0; i < FL; i++) begin
            send_bit(bits[i]);
            vmask[i] = p_valid;
            bmask[i] = busy;
        end
    endtask

    initial begin
        reset = 1'b0; s_in = 1'b0; p_ready = 1'b0; clr_overrun = 1'b0;

        // reset held with s_in toggling
        send_bit(1'b1);
        send_bit(1'b0);
        check("rst_p_out", 32'(p_out), 32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            check("idle_valid", 32'(p_valid), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
        end

        // single frame
        p_ready = 1'b1;
        send_frame(mkf(4'hD, 1'b1), vm, bm);
        check("single_vmask", 32'(vm), 32'(VM_NEW));
        check("single_bmask", 32'(bm), 32'(BM_EXP));
        check("single_p_out", 32'(p_out), 32'hD);
        check("single_perr", 32'(parity_err), 32'h0);
        send_bit(1'b0);
        check("single_drop_valid", 32'(p_valid), 32'h0);
        check("single_hold_p_out", 32'(p_out), 32'hD);

        // back-to-back frames
        send_frame(mkf(4'hD, 1'b1), vm, bm);
        check("b2b1_vmask", 32'(vm), 32'(VM_NEW));
        check("b2b1_p_out", 32'(p_out), 32'hD);
        send_frame(mkf(4'h4, 1'b1), vm, bm);
        check("b2b2_vmask", 32'(vm), 32'(VM_NEW));
        check("b2b2_bmask", 32'(bm), 32'(BM_EXP));
        check("b2b2_p_out", 32'(p_out), 32'h4);
        send_bit(1'b0);
        check("b2b_drain", 32'(p_valid), 32'h0);

        // overrun
        p_ready = 1'b0;
        send_frame(mkf(4'hD, 1'b1), vm, bm);
        check("ovr1_vmask", 32'(vm), 32'(VM_NEW));
        send_frame(mkf(4'h4, 1'b1), vm, bm);
        check("ovr2_vmask", 32'(vm), 32'(VM_HELD));
        check("ovr_p_out", 32'(p_out), 32'hD);
        check("ovr_flag", 32'(overrun), 32'h1);
        p_ready = 1'b1;
        send_bit(1'b0);
        check("ovr_accept_valid", 32'(p_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        p_ready = 1'b0;
        clr_overrun = 1'b1;
        send_bit(1'b0);
        check("ovr_clear", 32'(overrun), 32'h0);
        clr_overrun = 1'b0;

        // drop while clearing: drop wins
        send_frame(mkf(4'hD, 1'b1), vm, bm);
        clr_overrun = 1'b1;
        send_frame(mkf(4'h4, 1'b1), vm, bm);
        check("ovr_prio", 32'(overrun), 32'h1);
        clr_overrun = 1'b0;
        send_bit(1'b0);
        check("ovr_prio_hold", 32'(overrun), 32'h1);
        clr_overrun = 1'b1;
        send_bit(1'b0);
        check("ovr_prio_clear", 32'(overrun), 32'h0);
        clr_overrun = 1'b0;
        p_ready = 1'b1;
        send_bit(1'b0);
        check("ovr_final_drain", 32'(p_valid), 32'h0);

        // reset mid-frame
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy", 32'(busy), 32'h1);
        #1 reset = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(p_valid), 32'h0);
        check("mid_rst_p_out", 32'(p_out), 32'h0);
        reset = 1'b1;
        tick();
        check("mid_post_valid", 32'(p_valid), 32'h0);
        send_frame(mkf(4'hF, 1'b0), vm, bm);
        check("mid_vmask", 32'(vm), 32'(VM_NEW));
        check("mid_p_out", 32'(p_out), 32'hF);

`ifdef SR_DESER_PARITY_EN
        send_frame(mkf(4'hD, 1'b1), vm, bm);
        check("par_ok_vmask", 32'(vm), 32'(VM_NEW));
        check("par_ok_p_out", 32'(p_out), 32'hD);
        check("par_ok_perr", 32'(parity_err), 32'h0);
        send_frame(mkf(4'hD, 1'b0), vm, bm);
        check("par_bad_vmask", 32'(vm), 32'(VM_NEW));
        check("par_bad_p_out", 32'(p_out), 32'hD);
        check("par_bad_perr", 32'(parity_err), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_deserializer.md
Name: sr_deserializer

Overview:
- Downstream consumer of the serial shift-register stage. Takes its 1-bit s_out stream and detects a start bit.
- Captures WIDTH data bits and presents each word on a parallel valid/ready interface through a one-entry holding buffer.
- Flags words lost to back-pressure with a sticky overrun flag.

Parameters:
- WIDTH, 4, data bits per frame (≥2).
- LSB_FIRST, 1: 1 = first data bit lands in p_out[0]; 0 = first data bit lands in p_out[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock, shared with the upstream shift register.
- reset  input  1  asynchronous, active-low reset.
- s_in  input  1  serial stream, sampled every rising edge.
- p_ready  input  1  consumer accepts the word when high with p_valid.
- clr_overrun  input  1  synchronous clear of overrun.
- p_out  output  WIDTH  held word; stable while p_valid=1.
- p_valid  output  1  holding buffer full.
- busy  output  1  frame reception in progress.
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity status of the word in p_out.

Behaviour:
- Reset (reset=0, async): state=IDLE; bit counter=0; capture register=0; p_out=0; p_valid=0; busy=0; overrun=0; parity_err=0.
  - Reset mid-frame discards the partial word.
  - Reset while p_valid=1 drops the held word; overrun is not set.
- FSM states: IDLE, DATA, PAR (PAR exists only with the macro).
  - IDLE: s_in=1 at an edge is the start bit → DATA, counter=0. s_in=0 → stay in IDLE.
  - DATA: each edge shifts s_in into the capture register and increments the counter. The edge that samples bit WIDTH-1 goes → PAR (macro on) or → IDLE with commit (macro off).
  - PAR: one edge samples the parity bit → IDLE with commit.
- Timing:
  - busy=1 exactly while the state is DATA or PAR.
  - Frame = 1 start + WIDTH data (+1 parity) cycles.
  - The next start bit may arrive on the edge immediately after the commit edge (back-to-back frames, no gap).
- Latency: p_valid rises on the commit edge, i.e. WIDTH edges after the start-bit edge (WIDTH+1 with parity).
- Commit rules (evaluated at the commit edge):
  - p_valid=0, or p_valid=1 with p_ready=1: load p_out and parity_err; p_valid=1.
  - p_valid=1 with p_ready=0: new word dropped; p_out is unchanged; overrun←1.
- Handshake:
  - A transfer occurs at an edge where p_valid & p_ready.
  - If there is no commit on that edge, p_valid←0 and p_out holds its value.
  - p_ready while p_valid=0 has no effect.
- Overrun flag:
  - clr_overrun=1 clears overrun on the next edge.
  - A simultaneous drop takes priority: overrun stays 1.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1; it has no wrap state.

Optional Feature:
- Macro: SR_DESER_PARITY_EN.
- Defined:
  - Adds the PAR state; each frame carries one parity bit after the data.
  - Even parity: XOR over the data bits and the parity bit must be 0.
  - parity_err is loaded with the committed word (1 = mismatch). The word is still delivered.
- Undefined: no PAR state; parity_err is a constant 0.

Decomposition:
- Shared package/header sr_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_PAR=2'd2;
  - localparam CNT_W = $clog2(WIDTH).
- Sub-module sr_capture_reg (WIDTH, LSB_FIRST): the shift-in capture register with a shift enable. The FSM, counter and holding buffer stay in the top module.

Test Plan (WIDTH=4, LSB_FIRST=1, macro off unless stated):
- Reset check: hold reset=0 for 2 cycles with s_in toggling → all outputs 0, state IDLE. Release reset with s_in=0 for 5 cycles → p_valid stays 0, busy stays 0.
- Single frame: s_in = 1,1,0,1,1 on consecutive edges, p_ready=1 → p_valid=1 after the 5th edge with p_out=4'hD. p_valid drops the next edge. busy=1 for exactly 4 cycles.
- Back-to-back frames: frames 1,1,0,1,1 then 1,0,0,1,0 with no gap, p_ready=1 → words 4'hD then 4'h4. Two single-cycle p_valid pulses, 5 cycles apart.
- Overrun: p_ready=0 and two back-to-back frames (4'hD then 4'h4) → p_out stays 4'hD and overrun=1. Then p_ready=1 for 1 cycle → p_valid=0. Then clr_overrun=1 → overrun=0.
- Reset mid-frame: start bit plus 2 data bits, then reset=0 pulsed for 2 time units off-edge → busy=0 immediately and no p_valid. Frame 1,1,1,1,1 then yields 4'hF.
- Parity (SR_DESER_PARITY_EN): frame 1,1,0,1,1,1 → p_out=4'hD, parity_err=0. Frame 1,1,0,1,1,0 → p_out=4'hD, parity_err=1. p_valid rises 5 edges after the start-bit edge.
